// File: rtl/logic_issue_ctrl.sv
// Issue controller for the registered logic unit: reads operands from a local
// register file, drives the unit, and writes the captured result back.
//
// state   | meaning
// IDLE    | ready for an instruction; accept loads lu_* from the register file
// ISSUE   | logic unit samples lu_op/lu_a/lu_b
// CAPTURE | lu_result valid; write back, pulse res_valid, bump retired
module logic_issue_ctrl #(
  parameter int WIDTH = 32,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic [AW-1:0]    in_rd,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [2:0]       lu_op,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  input  logic [WIDTH-1:0] lu_result,
  output logic             res_valid,
  output logic [AW-1:0]    res_rd,
  output logic [WIDTH-1:0] res_data,
  output logic [15:0]      retired
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] regs [NREGS];
  logic [AW-1:0]    rd_q;
  logic [15:0]      retired_cnt;
  logic             accept;

  assign accept  = in_valid & in_ready;
  assign retired = retired_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Writeback is placed after the external load so it wins on an index clash.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      lu_op       <= '0;
      lu_a        <= '0;
      lu_b        <= '0;
      rd_q        <= '0;
      res_valid   <= 1'b0;
      res_rd      <= '0;
      res_data    <= '0;
      retired_cnt <= '0;
    end else begin
      res_valid <= 1'b0;
      if (ld_en) regs[ld_addr] <= ld_data;
      if (accept) begin
        rd_q  <= in_rd;
        lu_op <= in_op;
        lu_a  <= regs[in_rs1];
        lu_b  <= regs[in_rs2];
      end
      if (state == CAPTURE) begin
        regs[rd_q]  <= lu_result;
        res_data    <= lu_result;
        res_rd      <= rd_q;
        res_valid   <= 1'b1;
        retired_cnt <= retired_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/logic_issue_ctrl.md
Name: logic_issue_ctrl

Overview:
Initiator side of the logic-unit operation interface in the VLIW datapath. It accepts logic instructions over a valid/ready handshake and reads operands from an internal register file. It drives opcode and operands to the registered logic unit, captures the result one clock later, and writes it back to the destination register. It also reports each retired result and keeps a running count of retired instructions.

Parameters:
WIDTH, 32, operand/result width in bits
NREGS, 8, register file depth (power of two)
AW, 3, register index width (log2 NREGS)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  instruction offered
in_ready  output  1  controller can accept an instruction
in_op  input  3  logic opcode
in_rs1  input  AW  source A register index
in_rs2  input  AW  source B register index
in_rd  input  AW  destination register index
ld_en  input  1  external register load strobe
ld_addr  input  AW  load index
ld_data  input  WIDTH  load value
lu_op  output  3  opcode to logic unit (registered)
lu_a  output  WIDTH  operand A to logic unit (registered)
lu_b  output  WIDTH  operand B to logic unit (registered)
lu_result  input  WIDTH  registered logic unit output
res_valid  output  1  one-cycle retire pulse
res_rd  output  AW  retired destination index
res_data  output  WIDTH  retired result
retired  output  16  retired-instruction count, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (rst_n low at a posedge):
  - State goes to IDLE.
  - All register file entries, lu_op, lu_a, lu_b, res_rd, res_data and retired go to 0; res_valid goes to 0.
  - Any in-flight instruction is discarded with no writeback and no res_valid.
- Opcode map, which the logic unit implements:
  - 000 AND, 001 XOR, 010 NAND, 011 OR.
  - 100 NOT A, 101 NOR, 110 two's-complement negate of A, 111 XNOR.
  - The controller passes the opcode through unmodified.
- FSM states: IDLE, ISSUE, CAPTURE.
- in_ready is 1 only in IDLE (combinational from state).
- IDLE:
  - On in_valid & in_ready at edge E0, latch op/rd.
  - At the same edge, load lu_op <= in_op, lu_a <= reg[in_rs1], lu_b <= reg[in_rs2].
  - Operand reads see register contents before any write at E0.
  - Go to ISSUE.
- ISSUE: the logic unit samples lu_* at edge E1; go to CAPTURE.
- CAPTURE:
  - lu_result is valid.
  - At E2: reg[rd] <= lu_result, res_data <= lu_result, res_rd <= rd, res_valid <= 1, retired <= retired+1.
  - Go to IDLE.
- res_valid is high for exactly the one cycle after E2, then returns to 0 unless another retire follows.
- Throughput: one instruction per 3 cycles; latency E0 -> res_valid visible = 2 edges (after E2).
- Back-to-back:
  - A new instruction can be accepted in the cycle res_valid is high.
  - Its operand read sees the value written at E2 (no hazard).
- lu_op/lu_a/lu_b hold their last values outside ISSUE.
- ld_en is serviced in any state: reg[ld_addr] <= ld_data at the edge.
- Same edge, same index, ld_en and CAPTURE writeback: writeback wins.
- Same edge, ld_en and instruction accept: operands read pre-load contents.
- in_valid while not ready: the instruction is ignored. The source must hold it; the controller does not buffer.
- rs1 == rs2 == rd is legal.

Test Plan:
1. Reset then load reg1=0x0000FFFF, reg2=0x00FF00FF; issue AND (000) rs1=1 rs2=2 rd=3 -> lu_a=0x0000FFFF, lu_b=0x00FF00FF in ISSUE; res_valid 2 edges after accept; res_data=0x000000FF, res_rd=3; reg3=0x000000FF; retired=1.
2. Load reg4=0x00000005; issue negate (110) rs1=4 rd=5 -> res_data=0xFFFFFFFB. Then issue XNOR (111) rs1=5 rs2=5 rd=6 in the res_valid cycle -> accepted; result 0xFFFFFFFF.
3. Hold in_valid high continuously -> in_ready pattern 1,0,0 repeating; exactly one retire per 3 cycles; no instruction dropped or duplicated.
4. ld_en to reg3 with 0xDEADBEEF at the same edge as the CAPTURE writeback to rd=3 of 0x12345678 -> reg3=0x12345678.
5. Assert rst_n=0 during ISSUE -> no res_valid; retired unchanged at 0; all regs read 0; in_ready=1 after reset releases.
6. Preset retired to 0xFFFF via 65535 retires, then issue one more -> retired wraps to 0x0000.
